// File: rtl/fp_ctrl_pkg.sv
// Shared types and constants for the FP issue controller.
//   fpState_t          : controller state encoding
//   FP_ADD..FP_DIV     : FP op codes as presented on FpOpE
//   FP_QNAN            : canonical quiet NaN returned on watchdog expiry
//   DEFAULT_MULTI_MASK : op codes treated as multi-cycle (mul, div)
package fp_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      DONE  = 2'd2,
      DRAIN = 2'd3
   } fpState_t;

   localparam logic [1:0]  FP_ADD = 2'b00;
   localparam logic [1:0]  FP_SUB = 2'b01;
   localparam logic [1:0]  FP_MUL = 2'b10;
   localparam logic [1:0]  FP_DIV = 2'b11;

   localparam logic [31:0] FP_QNAN = 32'h7FC00000;

   localparam logic [3:0]  DEFAULT_MULTI_MASK = 4'b1100;

endpackage

// File: rtl/fp_issue_ctrl.sv
// Execute-stage sequencer for the multi-cycle FP unit.
// Spots a multi-cycle FP op in EX, pulses FpStart, holds F/D/E (FpStallE)
// and bubbles EX/MEM (FpBubbleM) until FpValid, then presents the captured
// result for one release cycle (FpSelHeld). An aborted op leaves the unit
// busy, so its late FpValid is drained and discarded before a new issue.
//
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   IsFpE, FpOpE         : FP instruction present in EX and its op code
//   Abort                : kill the in-flight FP op
//   FpValid, FpResultE   : result handshake from the FP unit
//   FpStart              : start pulse to the FP unit
//   FpStallE, FpBubbleM  : pipeline hold / EX-MEM clear
//   FpSelHeld            : steer FpResultHeld into the EX result mux
//   FpResultHeld         : captured result
//   FpBusy               : controller not idle
//   FpErr                : watchdog expired (DONE cycle only)
//
// Optional feature: define FP_TIMEOUT_EN to enable the TIMEOUT-cycle
// watchdog on WAIT and DRAIN; otherwise FpErr is tied low and both states
// wait indefinitely.
module fp_issue_ctrl
   import fp_ctrl_pkg::*;
#(
   parameter logic [3:0] MULTI_MASK = DEFAULT_MULTI_MASK,
   parameter int         TIMEOUT    = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        IsFpE,
   input  logic [1:0]  FpOpE,
   input  logic        Abort,
   input  logic        FpValid,
   input  logic [31:0] FpResultE,
   output logic        FpStart,
   output logic        FpStallE,
   output logic        FpBubbleM,
   output logic        FpSelHeld,
   output logic [31:0] FpResultHeld,
   output logic        FpBusy,
   output logic        FpErr
);

   if (TIMEOUT < 1) begin : gBadTimeout
      $error("fp_issue_ctrl: TIMEOUT must be at least 1");
   end

   fpState_t    state, stateNext;
   logic [31:0] heldNext;
   logic        multi;

   assign multi = IsFpE & MULTI_MASK[FpOpE];

`ifdef FP_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt;
   logic          timedOut, timedOutNext;
   logic          cntHit;

   // cnt is 0 in the first cycle of WAIT/DRAIN, so the TIMEOUT-th cycle
   // in the state is the one that sees TIMEOUT-1.
   assign cntHit = (cnt == CW'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt      <= '0;
         timedOut <= 1'b0;
      end else begin
         timedOut <= timedOutNext;
         if (stateNext != state) cnt <= '0;
         else                    cnt <= cnt + 1'b1;
      end
   end

   assign FpErr = timedOut & (state == DONE);
`else
   assign FpErr = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         FpResultHeld <= '0;
      end else begin
         state        <= stateNext;
         FpResultHeld <= heldNext;
      end
   end

   always_comb begin
      stateNext = state;
      heldNext  = FpResultHeld;
      FpStart   = 1'b0;
      FpStallE  = 1'b0;
      FpBubbleM = 1'b0;
      FpSelHeld = 1'b0;
`ifdef FP_TIMEOUT_EN
      timedOutNext = timedOut;
`endif
      unique case (state)
         IDLE: begin
            FpStart   = multi & ~Abort;
            FpStallE  = multi & ~Abort;
            FpBubbleM = multi & ~Abort;
            if (multi & ~Abort) stateNext = WAIT;
`ifdef FP_TIMEOUT_EN
            timedOutNext = 1'b0;
`endif
         end
         WAIT: begin
            FpStallE  = 1'b1;
            FpBubbleM = 1'b1;
            // Abort wins: a simultaneous FpValid belongs to the killed op.
            if (Abort) begin
               stateNext = DRAIN;
            end else if (FpValid) begin
               heldNext  = FpResultE;
               stateNext = DONE;
            end
`ifdef FP_TIMEOUT_EN
            else if (cntHit) begin
               heldNext     = FP_QNAN;
               timedOutNext = 1'b1;
               stateNext    = DONE;
            end
`endif
         end
         DONE: begin
            FpSelHeld = 1'b1;
            stateNext = IDLE;
`ifdef FP_TIMEOUT_EN
            // The unit is still working on the timed-out op.
            if (timedOut) stateNext = DRAIN;
            timedOutNext = 1'b0;
`endif
         end
         DRAIN: begin
            // Hold any new multi-cycle op until the orphan result drains.
            FpStallE  = multi;
            FpBubbleM = multi;
            if (FpValid) stateNext = IDLE;
`ifdef FP_TIMEOUT_EN
            else if (cntHit) stateNext = IDLE;
`endif
         end
         default: stateNext = IDLE;
      endcase
   end

   assign FpBusy = (state != IDLE);

endmodule

// File: tb/tb_fp_issue_ctrl.sv
// Directed bench for fp_issue_ctrl. Control outputs are checked every cycle
// on the falling edge; expected held results are queued when FpValid is
// driven and popped when FpSelHeld is seen.
module tb_fp_issue_ctrl;
   import fp_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        IsFpE;
   logic [1:0]  FpOpE;
   logic        Abort;
   logic        FpValid;
   logic [31:0] FpResultE;
   logic        FpStart, FpStallE, FpBubbleM, FpSelHeld, FpBusy, FpErr;
   logic [31:0] FpResultHeld;

   int nVec = 0;
   int nErr = 0;
   logic [31:0] expQ[$];

   always #5 clk = ~clk;

   fp_issue_ctrl #(.MULTI_MASK(DEFAULT_MULTI_MASK), .TIMEOUT(8)) dut (
      .clk(clk), .reset(reset), .IsFpE(IsFpE), .FpOpE(FpOpE), .Abort(Abort),
      .FpValid(FpValid), .FpResultE(FpResultE), .FpStart(FpStart),
      .FpStallE(FpStallE), .FpBubbleM(FpBubbleM), .FpSelHeld(FpSelHeld),
      .FpResultHeld(FpResultHeld), .FpBusy(FpBusy), .FpErr(FpErr)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nVec++;
      assert (obs === exp) else begin
         nErr++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, check outputs at negedge, advance past posedge.
   task automatic step(input string tag, input logic isFp, input logic [1:0] op,
                       input logic ab, input logic vld, input logic [31:0] res,
                       input logic eStart, input logic eStall, input logic eBub,
                       input logic eSel, input logic eBusy, input logic eErr);
      logic [31:0] e;
      IsFpE = isFp; FpOpE = op; Abort = ab; FpValid = vld; FpResultE = res;
      @(negedge clk);
      chk({tag, ".start"},  {31'd0, FpStart},   {31'd0, eStart});
      chk({tag, ".stall"},  {31'd0, FpStallE},  {31'd0, eStall});
      chk({tag, ".bubble"}, {31'd0, FpBubbleM}, {31'd0, eBub});
      chk({tag, ".sel"},    {31'd0, FpSelHeld}, {31'd0, eSel});
      chk({tag, ".busy"},   {31'd0, FpBusy},    {31'd0, eBusy});
      chk({tag, ".err"},    {31'd0, FpErr},     {31'd0, eErr});
      if (FpSelHeld === 1'b1) begin
         if (expQ.size() == 0) begin
            nVec++; nErr++;
            $error("FAIL %s.held observed=%h expected=<no result queued>", tag, FpResultHeld);
         end else begin
            e = expQ.pop_front();
            chk({tag, ".held"}, FpResultHeld, e);
         end
      end
      @(posedge clk); #1;
   endtask

   initial begin
      reset = 1'b1; IsFpE = 1'b0; FpOpE = FP_ADD; Abort = 1'b0;
      FpValid = 1'b0; FpResultE = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // Reset state
      step("rst", 0, FP_ADD, 0, 0, 0,  0, 0, 0, 0, 0, 0);
      chk("rst.held", FpResultHeld, 32'h0);

      // Single-cycle ops pass through
      step("add", 1, FP_ADD, 0, 0, 0,  0, 0, 0, 0, 0, 0);
      step("add", 1, FP_ADD, 0, 0, 0,  0, 0, 0, 0, 0, 0);
      step("sub", 1, FP_SUB, 0, 0, 0,  0, 0, 0, 0, 0, 0);
      // Abort in IDLE suppresses the issue and changes nothing
      step("abIdle", 1, FP_MUL, 1, 0, 0,  0, 0, 0, 0, 0, 0);

      // Division, FpValid 5 cycles after start: 6 stall cycles
      step("div.s",  1, FP_DIV, 0, 0, 0,  1, 1, 1, 0, 0, 0);
      for (int i = 0; i < 4; i++)
         step("div.w", 1, FP_DIV, 0, 0, 0,  0, 1, 1, 0, 1, 0);
      expQ.push_back(32'h3F800000);
      step("div.v",  1, FP_DIV, 0, 1, 32'h3F800000,  0, 1, 1, 0, 1, 0);
      step("div.d",  1, FP_DIV, 0, 0, 0,  0, 0, 0, 1, 1, 0);
      step("div.i",  0, FP_ADD, 0, 0, 0,  0, 0, 0, 0, 0, 0);

      // Abort in 2nd WAIT cycle, then a mul waits for the orphan result
      step("ab.s",   1, FP_MUL, 0, 0, 0,  1, 1, 1, 0, 0, 0);
      step("ab.w1",  1, FP_MUL, 0, 0, 0,  0, 1, 1, 0, 1, 0);
      step("ab.w2",  1, FP_MUL, 1, 0, 0,  0, 1, 1, 0, 1, 0);
      for (int i = 0; i < 3; i++)
         step("ab.dr", 1, FP_MUL, 0, 0, 0,  0, 1, 1, 0, 1, 0);
      step("ab.orph", 1, FP_MUL, 0, 1, 32'hDEADBEEF,  0, 1, 1, 0, 1, 0);
      chk("ab.heldKept", FpResultHeld, 32'h3F800000);
      step("ab.s2",  1, FP_MUL, 0, 0, 0,  1, 1, 1, 0, 0, 0);
      expQ.push_back(32'h40000000);
      step("ab.v2",  1, FP_MUL, 0, 1, 32'h40000000,  0, 1, 1, 0, 1, 0);
      step("ab.d2",  1, FP_MUL, 0, 0, 0,  0, 0, 0, 1, 1, 0);
      step("ab.i",   0, FP_ADD, 0, 0, 0,  0, 0, 0, 0, 0, 0);

      // Abort and FpValid together: drain, no release pulse
      step("av.s",   1, FP_DIV, 0, 0, 0,  1, 1, 1, 0, 0, 0);
      step("av.w",   1, FP_DIV, 1, 1, 32'h11111111,  0, 1, 1, 0, 1, 0);
      step("av.dr",  0, FP_ADD, 0, 0, 0,  0, 0, 0, 0, 1, 0);
      step("av.dv",  0, FP_ADD, 0, 1, 32'h22222222,  0, 0, 0, 0, 1, 0);
      step("av.i",   0, FP_ADD, 0, 0, 0,  0, 0, 0, 0, 0, 0);
      chk("av.held", FpResultHeld, 32'h40000000);

      // Reset in WAIT
      step("rw.s",   1, FP_MUL, 0, 0, 0,  1, 1, 1, 0, 0, 0);
      step("rw.w",   1, FP_MUL, 0, 0, 0,  0, 1, 1, 0, 1, 0);
      reset = 1'b1; IsFpE = 1'b0;
      @(posedge clk); #1 reset = 1'b0;
      step("rw.i",   0, FP_ADD, 0, 0, 0,  0, 0, 0, 0, 0, 0);
      chk("rw.held", FpResultHeld, 32'h0);
      step("rw.s2",  1, FP_MUL, 0, 0, 0,  1, 1, 1, 0, 0, 0);
      step("rw.w2",  1, FP_MUL, 0, 0, 0,  0, 1, 1, 0, 1, 0);
      expQ.push_back(32'h12345678);
      step("rw.v2",  1, FP_MUL, 0, 1, 32'h12345678,  0, 1, 1, 0, 1, 0);
      step("rw.d2",  1, FP_MUL, 0, 0, 0,  0, 0, 0, 1, 1, 0);
      step("rw.i2",  0, FP_ADD, 0, 0, 0,  0, 0, 0, 0, 0, 0);

`ifdef FP_TIMEOUT_EN
      // Watchdog: 8 WAIT cycles, qNaN release with FpErr, 8 DRAIN cycles
      step("to.s",   1, FP_DIV, 0, 0, 0,  1, 1, 1, 0, 0, 0);
      for (int i = 0; i < 7; i++)
         step("to.w", 1, FP_DIV, 0, 0, 0,  0, 1, 1, 0, 1, 0);
      expQ.push_back(FP_QNAN);
      step("to.w8",  1, FP_DIV, 0, 0, 0,  0, 1, 1, 0, 1, 0);
      step("to.d",   1, FP_DIV, 0, 0, 0,  0, 0, 0, 1, 1, 1);
      for (int i = 0; i < 8; i++)
         step("to.dr", 0, FP_ADD, 0, 0, 0,  0, 0, 0, 0, 1, 0);
      step("to.i",   0, FP_ADD, 0, 0, 0,  0, 0, 0, 0, 0, 0);
`endif

      chk("sb.empty", 32'(expQ.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end

endmodule
